// File: rtl/drbg_keystream_fetcher_if.sv
// DRBG request/response and keystream signals of drbg_keystream_fetcher.
// slave = fetcher side, master = DRBG/scrambler/control side.
interface drbg_keystream_fetcher_if #(
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic                 init_ready;
  logic                 next_bits_ready;
  logic [255:0]         random_bits;
  logic                 busy;
  logic                 next_bits;
  logic                 next_seed;
  logic [OUT_WIDTH-1:0] ks_data;
  logic                 ks_valid;
  logic                 ks_ready;
  logic                 flush;
  logic [LW-1:0]        level;
  logic [31:0]          words_fetched;

  modport slave (
    input  init_ready, next_bits_ready, random_bits, busy, ks_ready, flush,
    output next_bits, next_seed, ks_data, ks_valid, level, words_fetched
  );

  modport master (
    output init_ready, next_bits_ready, random_bits, busy, ks_ready, flush,
    input  next_bits, next_seed, ks_data, ks_valid, level, words_fetched
  );
endinterface

// File: rtl/drbg_keystream_fetcher.sv
// Pulls 256-bit words from hash_drbg_sha256 into a small FIFO and serves them as an
// OUT_WIDTH-bit valid/ready keystream; pulses next_seed every RESEED_INTERVAL words.
module drbg_keystream_fetcher #(
  parameter int OUT_WIDTH       = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int RESEED_INTERVAL = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  drbg_keystream_fetcher_if.slave  bus
);
  localparam int NSL = 256 / OUT_WIDTH;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    WAIT_INIT, IDLE, REQ, GAP, RESEED, WAIT_RS
  } state_t;

  state_t        state_q, state_d;
  logic          fall_seen_q, fall_seen_d;
  logic          nbr_q;
  logic [31:0]   reseed_cnt_q, reseed_cnt_d;
  logic [31:0]   words_q, words_d;

  logic [255:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [IW-1:0] idx_q;

  logic          next_bits, cap, push, pop, ks_valid, last_slice, take;
  logic [31:0]   shamt;
  logic [255:0]  head_shift;

  assign next_bits  = (state_q == REQ);
  assign cap        = bus.next_bits_ready & ~nbr_q & next_bits;
  assign ks_valid   = (level_q != '0);
  assign last_slice = (idx_q == IW'(NSL - 1));
  assign take       = ks_valid & bus.ks_ready;
  assign pop        = take & last_slice;

  always_comb begin
    state_d      = state_q;
    fall_seen_d  = fall_seen_q;
    reseed_cnt_d = reseed_cnt_q;
    words_d      = words_q;
    push         = 1'b0;
    unique case (state_q)
      WAIT_INIT: if (bus.init_ready) state_d = IDLE;
      IDLE: begin
        if ((level_q < LW'(FIFO_DEPTH)) && !bus.busy && bus.init_ready) state_d = REQ;
      end
      REQ: begin
        // Losing init_ready abandons the request even if a word arrives this cycle.
        if (!bus.init_ready) begin
          state_d = WAIT_INIT;
        end else if (cap) begin
          push    = 1'b1;
          words_d = words_q + 32'd1;
          if (reseed_cnt_q == 32'(RESEED_INTERVAL - 1)) begin
            reseed_cnt_d = '0;
            state_d      = RESEED;
          end else begin
            reseed_cnt_d = reseed_cnt_q + 32'd1;
            state_d      = GAP;
          end
        end
      end
      GAP: state_d = IDLE;
      RESEED: begin
        fall_seen_d = 1'b0;
        state_d     = WAIT_RS;
      end
      WAIT_RS: begin
        if (!bus.init_ready) begin
          fall_seen_d = 1'b1;
        end else if (fall_seen_q) begin
          fall_seen_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_INIT;
      fall_seen_q  <= 1'b0;
      nbr_q        <= 1'b0;
      reseed_cnt_q <= '0;
      words_q      <= '0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      idx_q        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      fall_seen_q  <= fall_seen_d;
      nbr_q        <= bus.next_bits_ready;
      reseed_cnt_q <= reseed_cnt_d;
      words_q      <= words_d;
      // Flush empties the buffer only; a word captured this cycle is still counted.
      if (bus.flush) begin
        level_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        idx_q    <= '0;
      end else begin
        level_q <= level_d;
        if (push) begin
          mem_q[wr_ptr_q] <= bus.random_bits;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (take) begin
          if (last_slice) begin
            idx_q    <= '0;
            rd_ptr_q <= rd_ptr_q + AW'(1);
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
      end
    end
  end

  assign shamt      = 32'(idx_q) * 32'(OUT_WIDTH);
  assign head_shift = mem_q[rd_ptr_q] >> shamt;

  assign bus.next_bits     = next_bits;
  assign bus.next_seed     = (state_q == RESEED);
  assign bus.ks_data       = head_shift[OUT_WIDTH-1:0];
  assign bus.ks_valid      = ks_valid;
  assign bus.level         = level_q;
  assign bus.words_fetched = words_q;
endmodule

// File: tb/tb_drbg_keystream_fetcher.sv
// Scoreboard bench for drbg_keystream_fetcher: a DRBG model queues expected slices,
// a monitor checks every accepted slice against that queue.
module tb_drbg_keystream_fetcher;
  localparam int OW = 32;
  localparam int FD = 4;
  localparam int RI = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  drbg_keystream_fetcher_if #(.OUT_WIDTH(OW), .FIFO_DEPTH(FD)) bus ();

  drbg_keystream_fetcher #(
    .OUT_WIDTH(OW), .FIFO_DEPTH(FD), .RESEED_INTERVAL(RI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  localparam logic [255:0] W0 =
    256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
  logic [31:0] w0_sl [8] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233,
                             32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567};

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  int unsigned wi = 0;
  int          n_pres = 0;
  int          n_seed = 0;
  int          n_slices = 0;
  bit          drbg_en = 1'b0;
  bit          ir_main = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] data_prev = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word 0 is the hand vector; later words have slice j = {word index, j, 5A}.
  task automatic present();
    logic [255:0] w;
    logic [31:0]  s;
    if (wi == 0) begin
      w = W0;
      for (int j = 0; j < 8; j++) exp_q.push_back(w0_sl[j]);
    end else begin
      for (int j = 0; j < 8; j++) begin
        s = {wi[15:0], 8'(j), 8'h5A};
        w[32*j +: 32] = s;
        exp_q.push_back(s);
      end
    end
    wi++;
    bus.random_bits     = w;
    bus.next_bits_ready = 1'b1;
    n_pres++;
  endtask

  task automatic reseed_seq();
    n_seed++;
    check("words_at_seed", 64'(bus.words_fetched), 64'(RI * n_seed));
    bus.next_bits_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("seed_single_cycle", 64'(bus.next_seed), 64'd0);
      check("nb_before_fall", 64'(bus.next_bits), 64'd0);
    end
    bus.init_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nb_before_rise", 64'(bus.next_bits), 64'd0);
    end
    bus.init_ready = 1'b1;
  endtask

  // DRBG model: owns init_ready, next_bits_ready and random_bits.
  initial begin
    bus.init_ready      = 1'b0;
    bus.next_bits_ready = 1'b0;
    bus.random_bits     = '0;
    forever begin
      @(negedge clk);
      bus.init_ready = ir_main;
      if (!reset_n) begin
        bus.next_bits_ready = 1'b0;
        n_pres = 0;
        n_seed = 0;
        continue;
      end
      if (bus.next_seed) begin
        reseed_seq();
      end else if (bus.next_bits_ready && !bus.next_bits) begin
        bus.next_bits_ready = 1'b0;
      end else if (drbg_en && bus.next_bits && !bus.next_bits_ready) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (drbg_en && reset_n && bus.next_bits) present();
      end
    end
  end

  // Monitor: checks accepted slices and stability under backpressure.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n || bus.flush) begin
        exp_q.delete();
        hold_prev = 1'b0;
        continue;
      end
      if (hold_prev) begin
        check("hold_valid", 64'(bus.ks_valid), 64'd1);
        check("hold_data", 64'(bus.ks_data), 64'(data_prev));
      end
      if (bus.ks_valid && bus.ks_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_slice: got %h, expected none", bus.ks_data);
        end else begin
          check("slice", 64'(bus.ks_data), 64'(exp_q.pop_front()));
        end
        n_slices++;
      end
      hold_prev = bus.ks_valid && !bus.ks_ready;
      data_prev = bus.ks_data;
    end
  end

  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ks_ready = 1'b1;
    end
    @(negedge clk);
    bus.ks_ready = 1'b0;
  endtask

  task automatic wait_slices(input int target, input int budget, input string name);
    int c = 0;
    while (n_slices < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(n_slices >= target), 64'd1);
  endtask

  task automatic wait_level(input int lvl, input int budget, input string name);
    int c = 0;
    while (int'(bus.level) != lvl && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(name, 64'(bus.level), 64'(lvl));
  endtask

  task automatic wait_nb(input int budget, input string name);
    int c = 0;
    while (bus.next_bits !== 1'b1 && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(name, 64'(bus.next_bits), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int rises;
    logic nb_prev;
    bus.busy     = 1'b0;
    bus.ks_ready = 1'b0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle with DRBG not instantiated
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      check("t1_next_bits", 64'(bus.next_bits), 64'd0);
      check("t1_ks_valid", 64'(bus.ks_valid), 64'd0);
      check("t1_level", 64'(bus.level), 64'd0);
    end
    check("t1_words", 64'(bus.words_fetched), 64'd0);
    check("t1_next_seed", 64'(bus.next_seed), 64'd0);

    // Free-flowing stream, first word is the hand vector
    ir_main      = 1'b1;
    bus.ks_ready = 1'b1;
    drbg_en      = 1'b1;
    wait_slices(n_slices + 24, 1000, "t2_stream_progress");

    // Backpressure fills the FIFO, then no further requests
    @(negedge clk);
    bus.ks_ready = 1'b0;
    wait_level(FD, 500, "t3_fill");
    repeat (10) @(negedge clk);
    p0 = n_pres;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("t3_nb_when_full", 64'(bus.next_bits), 64'd0);
      check("t3_level_full", 64'(bus.level), 64'(FD));
    end
    check("t3_no_capture_full", 64'(n_pres), 64'(p0));

    // busy blocks the request after one word drains; releasing it gives exactly one
    bus.busy = 1'b1;
    consume(8);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      check("t3_nb_busy", 64'(bus.next_bits), 64'd0);
    end
    check("t3_level_after_drain", 64'(bus.level), 64'(FD - 1));
    bus.busy = 1'b0;
    rises    = 0;
    nb_prev  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (bus.next_bits && !nb_prev) rises++;
      nb_prev = bus.next_bits;
    end
    check("t3_single_request", 64'(rises), 64'd1);
    check("t3_refilled", 64'(bus.level), 64'(FD));
    check("t3_one_capture", 64'(n_pres), 64'(p0 + 1));

    // Flush with level 3 and slice index 5
    drbg_en = 1'b0;
    consume(13);
    @(negedge clk);
    #1;
    check("t6_level_pre_flush", 64'(bus.level), 64'd3);
    check("t6_request_pending", 64'(bus.next_bits), 64'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("t6_level_flushed", 64'(bus.level), 64'd0);
    check("t6_valid_flushed", 64'(bus.ks_valid), 64'd0);
    drbg_en = 1'b1;
    wait_level(2, 300, "t6_refill");
    drbg_en = 1'b0;
    consume(8);

    // Asynchronous reset while a request is outstanding
    wait_nb(200, "t6_reach_req");
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_next_bits", 64'(bus.next_bits), 64'd0);
    check("rst_next_seed", 64'(bus.next_seed), 64'd0);
    check("rst_ks_valid", 64'(bus.ks_valid), 64'd0);
    check("rst_ks_data", 64'(bus.ks_data), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_words", 64'(bus.words_fetched), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Random backpressure against the reference queue
    drbg_en = 1'b1;
    p0 = n_slices;
    begin
      int c = 0;
      while (n_slices < p0 + 1200 && c < 20000) begin
        @(negedge clk);
        bus.ks_ready = 1'($urandom_range(0, 1));
        c++;
      end
    end
    check("t5_random_progress", 64'(n_slices >= p0 + 1200), 64'd1);

    // Drain and reconcile counts
    @(negedge clk);
    drbg_en      = 1'b0;
    bus.ks_ready = 1'b1;
    begin
      int c = 0;
      while ((exp_q.size() != 0 || bus.ks_valid) && c < 400) begin
        @(negedge clk);
        #1;
        c++;
      end
    end
    repeat (2) @(negedge clk);
    #3;
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    check("end_level", 64'(bus.level), 64'd0);
    check("end_words_vs_model", 64'(bus.words_fetched), 64'(n_pres));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
